// File: rtl/npc_imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package npc_imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_e;

    localparam logic [31:0] IMEM_ERR_INST = 32'h0000_0000;
    localparam logic [31:0] RV_NOP        = 32'h0000_0013;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request / instruction response channel between the core and the responder.
interface imem_fetch_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_inst, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_inst, rsp_err
    );

endinterface

// File: rtl/imem_array.sv
// Synchronous 1R1W instruction RAM; a same-edge read and write of one word returns the old data.
module imem_array #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_data
);

    logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset; the array keeps the loaded image.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch responder: decodes the pc, reads the instruction RAM at acceptance and
// returns the word after a fixed latency over a valid/ready response channel.
module imem_fetch_responder
    import npc_imem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    imem_fetch_responder_if.slave   bus,
    input  logic                    ld_en,
    input  logic [DEPTH_LOG2-1:0]   ld_addr,
    input  logic [31:0]             ld_data,
    output logic [31:0]             fetch_cnt
);

    localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;

    imem_state_e state;
    logic [3:0]  lat_cnt;
    logic        rsp_valid_q;
    logic        err_q;
    logic [31:0] offset;
    logic        fault;
    logic        accept;
    logic [31:0] ram_q;

    assign offset        = bus.req_addr - BASE_ADDR;
    assign fault         = (bus.req_addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    imem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (accept && !fault),
        .rd_addr (offset[DEPTH_LOG2+1:2]),
        .rd_data (ram_q),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data)
    );

    // The RAM output register already holds the word from the acceptance edge,
    // so masking it by the registered fault flag keeps LATENCY=1 in step.
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_inst  = err_q ? IMEM_ERR_INST : ram_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            fetch_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        err_q <= fault;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd1) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        lat_cnt     <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        fetch_cnt   <= fetch_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
